// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and helpers for the data-memory responder.
// Optional checking is enabled by defining DMEM_ERR_EN.
package dmem_pkg;

  // RISC-V load/store funct3 size/sign codes
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // True when funct3 names a real load (we=0) or store (we=1) size
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // True when a half access is odd or a word access is not 4-byte aligned
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational byte-lane formatting for loads and stores.
// Misaligned halves/words are force-aligned and unknown funct3 codes act as
// word accesses; flagging them as errors is done upstream when DMEM_ERR_EN
// is defined.
import dmem_pkg::*;

module dmem_lane_fmt (
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword
);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]  w_size;
  logic        w_uns;
  logic [1:0]  w_lane;
  logic [31:0] w_shift;

  // Decode access size, signedness and the (force-aligned) starting lane
  always_comb begin
    w_size = SZ_W;
    w_uns  = 1'b0;
    if (i_we) begin
      case (i_func3)
        F3_B:    w_size = SZ_B;
        F3_H:    w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end else begin
      case (i_func3)
        F3_B:    w_size = SZ_B;
        F3_BU:   begin w_size = SZ_B; w_uns = 1'b1; end
        F3_H:    w_size = SZ_H;
        F3_HU:   begin w_size = SZ_H; w_uns = 1'b1; end
        default: w_size = SZ_W;
      endcase
    end
    case (w_size)
      SZ_B:    w_lane = i_addr_lo;
      SZ_H:    w_lane = {i_addr_lo[1], 1'b0};
      default: w_lane = 2'd0;
    endcase
  end

  assign w_shift = i_rword >> {w_lane, 3'b000};

  // Load: pick the addressed lane and sign/zero extend it
  always_comb begin
    case (w_size)
      SZ_B:    o_load = w_uns ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      SZ_H:    o_load = w_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: o_load = w_shift;
    endcase
  end

  // Store: byte enables for the addressed lanes and data moved into place
  always_comb begin
    case (w_size)
      SZ_B:    o_be = 4'b0001 << w_lane;
      SZ_H:    o_be = 4'b0011 << w_lane;
      default: o_be = 4'b1111;
    endcase
    o_wword = i_wdata << {w_lane, 3'b000};
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with fixed latency.
// Define DMEM_ERR_EN to enable alignment, funct3 and range checking on
// o_rsp_err; otherwise accesses are force-aligned and addresses wrap.
import dmem_pkg::*;

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_func3,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [2:0]    r_func3;
  logic [31:0]   r_wdata;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_accept;
  logic          w_commit;
  logic          w_a_we;
  logic [31:0]   w_a_addr;
  logic [2:0]    w_a_func3;
  logic [31:0]   w_a_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic          w_err;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && i_req_valid;

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // access operands come straight from the request pins while idle.
  assign w_a_we    = w_idle ? i_req_we    : r_we;
  assign w_a_addr  = w_idle ? i_req_addr  : r_addr;
  assign w_a_func3 = w_idle ? i_req_func3 : r_func3;
  assign w_a_wdata = w_idle ? i_req_wdata : r_wdata;

  assign w_commit = (LATENCY == 1) ? w_accept
                                   : ((r_state == S_WAIT) && (r_cnt == '0));

  assign w_idx   = w_a_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];

`ifdef DMEM_ERR_EN
  assign w_err = !f3_legal(w_a_we, w_a_func3) ||
                 f3_misaligned(w_a_func3, w_a_addr[1:0]) ||
                 (|w_a_addr[31:AW+2]);
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^w_a_addr[31:AW+2];
  assign w_err = 1'b0;
`endif

  dmem_lane_fmt u_fmt (
    .i_we      (w_a_we),
    .i_func3   (w_a_func3),
    .i_addr_lo (w_a_addr[1:0]),
    .i_rword   (w_rword),
    .i_wdata   (w_a_wdata),
    .o_load    (w_load),
    .o_be      (w_be),
    .o_wword   (w_wword)
  );

  // Request FSM: accept, count down the latency, hold the response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_func3 <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_func3 <= i_req_func3;
            r_wdata <= i_req_wdata;
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_RESP: begin
          if (i_rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Response registers: loaded on the access edge, cleared when consumed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_commit) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (w_a_we || w_err) ? 32'd0 : w_load;
      r_rsp_err   <= w_err;
    end else if ((r_state == S_RESP) && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // RAM byte-lane write on the access edge; contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_commit && w_a_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wword[b*8 +: 8];
      end
    end
  end

  assign o_req_ready = w_idle;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder.
// Error-path steps are compiled in when DMEM_ERR_EN is defined.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_func3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_func3 (req_func3),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input string tag);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.tag   = tag;
    sb_q.push_back(e);
    req_we    = we;
    req_addr  = addr;
    req_func3 = f3;
    req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  // Waits until the request is accepted, then drops req_valid
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Waits for the response, checks latency and pops the scoreboard
  task automatic wait_rsp();
    int   k = 0;
    exp_t e;
    while (!rsp_valid && k < 100) begin
      step();
      k++;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("latency", 32'(k), 32'(LAT));
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
      check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
      $display("txn %-10s rdata=%h err=%b lat=%0d", e.tag, rsp_rdata, rsp_err, k);
    end
  endtask

  // Response taken at the next edge: valid falls and the FSM is idle again
  task automatic consume_chk(input string tag);
    step();
    check({tag, "_valid_low"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_hi"}, 32'(req_ready), 32'd1);
  endtask

  task automatic transact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
    drive_req(we, addr, f3, wdata, exp_rdata, exp_err, tag);
    wait_accept(tag);
    wait_rsp();
    consume_chk(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_func3 = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Word store/load and lane extraction
    transact(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    transact(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    transact(1'b0, 32'h13, 3'd0, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_13");
    transact(1'b0, 32'h13, 3'd4, 32'h0, 32'h000000DE, 1'b0, "lbu_13");
    transact(1'b0, 32'h12, 3'd1, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_12");
    transact(1'b0, 32'h10, 3'd5, 32'h0, 32'h0000BEEF, 1'b0, "lhu_10");
    transact(1'b1, 32'h11, 3'd0, 32'h55, 32'h0, 1'b0, "sb_11");
    transact(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD55EF, 1'b0, "lw_10b");
    transact(1'b1, 32'h20, 3'd2, 32'h0BADF00D, 32'h0, 1'b0, "sw_20");

`ifdef DMEM_ERR_EN
    transact(1'b0, 32'h12, 3'd2, 32'h0, 32'h0, 1'b1, "lw_mis");
    transact(1'b1, 32'h21, 3'd1, 32'h1234, 32'h0, 1'b1, "sh_mis");
    transact(1'b0, 32'h20, 3'd2, 32'h0, 32'h0BADF00D, 1'b0, "lw_20");
    transact(1'b0, 32'h400, 3'd2, 32'h0, 32'h0, 1'b1, "lw_range");
    transact(1'b0, 32'h10, 3'd3, 32'h0, 32'h0, 1'b1, "ld_f3_3");
    transact(1'b1, 32'h10, 3'd4, 32'h1, 32'h0, 1'b1, "st_f3_4");
`else
    transact(1'b0, 32'h12, 3'd2, 32'h0, 32'hDEAD55EF, 1'b0, "lw_mis");
    transact(1'b1, 32'h21, 3'd1, 32'h1234, 32'h0, 1'b0, "sh_mis");
    transact(1'b0, 32'h20, 3'd2, 32'h0, 32'h0BAD1234, 1'b0, "lw_20");
    transact(1'b0, 32'h410, 3'd2, 32'h0, 32'hDEAD55EF, 1'b0, "lw_wrap");
    transact(1'b0, 32'h10, 3'd3, 32'h0, 32'hDEAD55EF, 1'b0, "ld_f3_3");
`endif
    transact(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD55EF, 1'b0, "lw_after");

    // Backpressure: response held, a second request waits its turn
    rsp_ready = 1'b0;
    drive_req(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD55EF, 1'b0, "lw_hold");
    wait_accept("lw_hold");
    wait_rsp();
    drive_req(1'b0, 32'h10, 3'd4, 32'h0, 32'h000000EF, 1'b0, "lbu_queued");
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, 32'hDEAD55EF);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    consume_chk("hold");
    wait_accept("lbu_queued");
    wait_rsp();
    consume_chk("lbu_queued");

    // Reset during WAIT aborts a pending store
    transact(1'b1, 32'h0, 3'd2, 32'h0, 32'h0, 1'b0, "sw_0_zero");
    transact(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD55EF, 1'b0, "lw_pre_rst");
    req_we    = 1'b1;
    req_addr  = 32'h0;
    req_func3 = 3'd2;
    req_wdata = 32'h1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("wait_req_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_rdata", rsp_rdata, 32'd0);
    check("arst_rsp_err", 32'(rsp_err), 32'd0);
    #2 rst_n = 1'b1;
    step();
    transact(1'b0, 32'h0, 3'd2, 32'h0, 32'h0, 1'b0, "lw_0_post");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory interface: accepts one load/store request at a time from the core over a valid/ready handshake, services it from an internal word-organised RAM after a fixed configurable latency, and returns a formatted response. It handles byte/half/word lanes with sign or zero extension on loads and byte-masked writes on stores. It replaces the zero-latency combinational data memory once the core issues requests through a handshake.

## Interface
- DEPTH_WORDS, 256, RAM depth in 32-bit words (power of two, ≥ 4)
- LATENCY, 2, cycles from request accept edge to rsp_valid high (≥ 1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high exactly when FSM is IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_func3  in  3  RISC-V funct3 size/sign code
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request faulted

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/func3/wdata, load latency counter with LATENCY-1, go to WAIT (or straight to RESP if LATENCY=1).
- WAIT: decrement counter each cycle; at 0 → RESP.
- On the WAIT→RESP (or IDLE→RESP) edge: perform the RAM access, register rsp_rdata and rsp_err, set rsp_valid.
- RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready; then → IDLE, rsp_valid=0 next cycle.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
- Loads: func3 0=LB (sign-ext byte), 1=LH (sign-ext half), 2=LW, 4=LBU, 5=LHU; lane selected by addr[1:0] (half uses addr[1]).
- Stores: func3 0=SB, 1=SH, 2=SW; write only the addressed bytes with req_wdata[7:0]/[15:0]/[31:0]; other bytes unchanged.
- Errors (macro enabled): illegal func3 (loads 3/6/7, stores ≥ 3), half with addr[0]=1, word with addr[1:0]≠0, or addr ≥ 4·DEPTH_WORDS → rsp_err=1, rsp_rdata=0, no RAM write. Error still takes full LATENCY.
- Exactly one request outstanding; req_valid while not IDLE is ignored (not accepted, not lost—initiator must hold it).

## Timing
- Reset (reset low, async): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. RAM contents not reset.
- Accept at edge N → rsp_valid high after edge N+LATENCY.
- Store becomes visible to a subsequent load in the same cycle the store response is valid.
- rsp_ready high at the same edge rsp_valid rises → response consumed at the following edge; minimum request-to-request spacing LATENCY+2 cycles.
- Reset asserted during WAIT: request aborted, pending store not written. Asserted during RESP: store already committed, response discarded.
- req_ready is a pure function of state (no combinational path from req_valid or rsp_ready).

## Configuration
- DMEM_ERR_EN defined: alignment, func3 and range checks as above; rsp_err driven.
- Not defined: rsp_err tied 0; misaligned half/word force-aligned (addr[0], or addr[1:0], treated as 0); addresses wrap modulo 4·DEPTH_WORDS; illegal func3 treated as LW/SW.

## Structure
- Package dmem_pkg: funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU, state enum (IDLE/WAIT/RESP).
- Sub-module dmem_lane_fmt (combinational): load lane extract + extension, store byte-enable and data merge; FSM, counter and RAM stay in dmem_responder.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly LATENCY cycles after each accept.
- After above, LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x55 @0x11 then LW @0x10 → 0xDEAD55EF.
- DMEM_ERR_EN: LW @0x12 → rsp_err=1, rsp_rdata=0; SH 0x1234 @0x21 → rsp_err=1, LW @0x20 unchanged.
- Hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata stable, req_ready=0 throughout; new req_valid not accepted until rsp taken.
- Reset low during WAIT of SW 0x1 @0x0 (prior 0x0) → outputs to reset values immediately; after release LW @0x0 → 0x0.
